// File: rtl/verificador_tiro.sv
// verificador_tiro: shot checker for the battleship game.
// Reads the five confirmed map rows and classifies every opponent shot as a
// hit, miss, repeat or invalid. It also tracks the cells already fired, the
// shots left and the hit count, and declares victory or defeat.
//
// Ports:
//   clk_i, rst_ni               clock and async active-low reset
//   enable_i                    attack phase; shots are ignored while low
//   novo_jogo_i                 synchronous clear of all game state
//   mapa0_i..mapa4_i [6:0]      map rows, bit (6-c) = column c, 1 = ship
//   linha_i, coluna_i [2:0]     shot coordinate
//   atirar_i                    fire button (debounced level, rising edge acts)
//   acerto_o/erro_o/repetido_o/invalido_o   one-clock result pulses
//   tiros0_o..tiros4_o [6:0]    cells already fired (same layout as mapa)
//   tiros_restantes_o [4:0]     valid shots left
//   acertos_o [5:0]             hits so far
//   vitoria_o, derrota_o        end-of-game levels
//   ocupado_o                   high while a shot is being evaluated
module verificador_tiro #(
    parameter int MAX_TIROS = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       novo_jogo_i,
    input  logic [6:0] mapa0_i,
    input  logic [6:0] mapa1_i,
    input  logic [6:0] mapa2_i,
    input  logic [6:0] mapa3_i,
    input  logic [6:0] mapa4_i,
    input  logic [2:0] linha_i,
    input  logic [2:0] coluna_i,
    input  logic       atirar_i,
    output logic       acerto_o,
    output logic       erro_o,
    output logic       repetido_o,
    output logic       invalido_o,
    output logic [6:0] tiros0_o,
    output logic [6:0] tiros1_o,
    output logic [6:0] tiros2_o,
    output logic [6:0] tiros3_o,
    output logic [6:0] tiros4_o,
    output logic [4:0] tiros_restantes_o,
    output logic [5:0] acertos_o,
    output logic       vitoria_o,
    output logic       derrota_o,
    output logic       ocupado_o
);

    typedef enum logic [1:0] {OCIOSO, VERIFICA, FIM} estado_t;

    typedef struct packed {
        logic acerto;
        logic erro;
        logic repetido;
        logic invalido;
    } pulsos_t;

    estado_t          estado_q, estado_d;
    logic             atirar_q;
    logic [2:0]       lin_q, lin_d, col_q, col_d;
    logic [4:0][6:0]  tiros_q, tiros_d;
    logic [4:0]       rest_q, rest_d;
    logic [5:0]       acertos_q, acertos_d;
    logic             vitoria_q, vitoria_d, derrota_q, derrota_d;
    pulsos_t          pulsos_q, pulsos_d;

    logic [4:0][6:0]  mapa;
    logic             borda;
    logic [2:0]       bit_col;

    assign mapa    = {mapa0_i, mapa1_i, mapa2_i, mapa3_i, mapa4_i};
    // Row r sits at index 4-r of the packed arrays so row 0 maps to the top slice.
    assign borda   = atirar_i & ~atirar_q;
    assign bit_col = 3'd6 - col_q;

    always_comb begin
        estado_d  = estado_q;
        lin_d     = lin_q;
        col_d     = col_q;
        tiros_d   = tiros_q;
        rest_d    = rest_q;
        acertos_d = acertos_q;
        vitoria_d = vitoria_q;
        derrota_d = derrota_q;
        pulsos_d  = '0;

        case (estado_q)
            OCIOSO: begin
                if (borda && enable_i) begin
                    lin_d    = linha_i;
                    col_d    = coluna_i;
                    estado_d = VERIFICA;
                end
            end
            VERIFICA: begin
                estado_d = OCIOSO;
                if (lin_q > 3'd4 || col_q > 3'd6) begin
                    pulsos_d.invalido = 1'b1;
                end else if (tiros_q[3'd4 - lin_q][bit_col]) begin
                    pulsos_d.repetido = 1'b1;
                end else begin
                    tiros_d[3'd4 - lin_q][bit_col] = 1'b1;
                    if (rest_q != 5'd0) rest_d = rest_q - 5'd1;
                    if (mapa[3'd4 - lin_q][bit_col]) begin
                        pulsos_d.acerto = 1'b1;
                        if (acertos_q != 6'd35) acertos_d = acertos_q + 6'd1;
                    end else begin
                        pulsos_d.erro = 1'b1;
                    end
                    // Victory wins over defeat when the last shot sinks the last cell.
                    if (pulsos_d.acerto && (mapa != '0) && ((tiros_d & mapa) == mapa)) begin
                        vitoria_d = 1'b1;
                        estado_d  = FIM;
                    end else if (rest_d == 5'd0) begin
                        derrota_d = 1'b1;
                        estado_d  = FIM;
                    end
                end
            end
            FIM: ;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            estado_q  <= OCIOSO;
            atirar_q  <= 1'b0;
            lin_q     <= '0;
            col_q     <= '0;
            tiros_q   <= '0;
            rest_q    <= 5'(MAX_TIROS);
            acertos_q <= '0;
            vitoria_q <= 1'b0;
            derrota_q <= 1'b0;
            pulsos_q  <= '0;
        end else if (novo_jogo_i) begin
            estado_q  <= OCIOSO;
            atirar_q  <= 1'b0;
            lin_q     <= '0;
            col_q     <= '0;
            tiros_q   <= '0;
            rest_q    <= 5'(MAX_TIROS);
            acertos_q <= '0;
            vitoria_q <= 1'b0;
            derrota_q <= 1'b0;
            pulsos_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            atirar_q  <= atirar_i;
            lin_q     <= lin_d;
            col_q     <= col_d;
            tiros_q   <= tiros_d;
            rest_q    <= rest_d;
            acertos_q <= acertos_d;
            vitoria_q <= vitoria_d;
            derrota_q <= derrota_d;
            pulsos_q  <= pulsos_d;
        end
    end

    assign acerto_o          = pulsos_q.acerto;
    assign erro_o            = pulsos_q.erro;
    assign repetido_o        = pulsos_q.repetido;
    assign invalido_o        = pulsos_q.invalido;
    assign tiros0_o          = tiros_q[4];
    assign tiros1_o          = tiros_q[3];
    assign tiros2_o          = tiros_q[2];
    assign tiros3_o          = tiros_q[1];
    assign tiros4_o          = tiros_q[0];
    assign tiros_restantes_o = rest_q;
    assign acertos_o         = acertos_q;
    assign vitoria_o         = vitoria_q;
    assign derrota_o         = derrota_q;
    assign ocupado_o         = (estado_q == VERIFICA);

endmodule

// File: tb/tb_verificador_tiro.sv
// Self-checking bench for verificador_tiro: directed scenarios plus random
// games, all checked against a cell/count level model of the game rules.
module tb_verificador_tiro;

    localparam int MAXT = 15;

    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b1, novo = 1'b0, atirar = 1'b0;
    logic [6:0] m0 = '0, m1 = '0, m2 = '0, m3 = '0, m4 = '0;
    logic [2:0] linha = '0, coluna = '0;
    logic       acerto, erro, repetido, invalido, vitoria, derrota, ocupado;
    logic [6:0] t0, t1, t2, t3, t4;
    logic [4:0] rest;
    logic [5:0] hits;

    verificador_tiro #(.MAX_TIROS(MAXT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .novo_jogo_i(novo),
        .mapa0_i(m0), .mapa1_i(m1), .mapa2_i(m2), .mapa3_i(m3), .mapa4_i(m4),
        .linha_i(linha), .coluna_i(coluna), .atirar_i(atirar),
        .acerto_o(acerto), .erro_o(erro), .repetido_o(repetido), .invalido_o(invalido),
        .tiros0_o(t0), .tiros1_o(t1), .tiros2_o(t2), .tiros3_o(t3), .tiros4_o(t4),
        .tiros_restantes_o(rest), .acertos_o(hits), .vitoria_o(vitoria),
        .derrota_o(derrota), .ocupado_o(ocupado)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    // Reference model: ship/fired grids plus plain counters.
    bit ship [5][7];
    bit shot [5][7];
    int m_rest, m_hits, m_ships;
    bit m_vit, m_der;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic set_map(input logic [6:0] r0, r1, r2, r3, r4);
        logic [6:0] rows [5];
        rows = '{r0, r1, r2, r3, r4};
        m0 = r0; m1 = r1; m2 = r2; m3 = r3; m4 = r4;
        m_ships = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++) begin
                ship[r][c] = rows[r][6-c];
                m_ships += int'(ship[r][c]);
            end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++) shot[r][c] = 1'b0;
        m_rest = MAXT; m_hits = 0; m_vit = 1'b0; m_der = 1'b0;
    endfunction

    task automatic chk_state();
        logic [34:0] ev;
        ev = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++) ev[(4-r)*7 + (6-c)] = shot[r][c];
        chk("tiros", {t0, t1, t2, t3, t4}, ev);
        chk("restantes", rest, m_rest);
        chk("acertos", hits, m_hits);
        chk("fim", {vitoria, derrota}, {m_vit, m_der});
    endtask

    task automatic novo_jogo();
        @(negedge clk); novo = 1'b1;
        @(negedge clk); novo = 1'b0;
        model_clear();
        #1 chk_state();
    endtask

    function automatic int npulses();
        return int'(acerto) + int'(erro) + int'(repetido) + int'(invalido);
    endfunction

    // One button press; hold = extra clocks the button stays high.
    task automatic fire(input int l, input int c, input bit en, input int hold);
        bit         acc;
        logic [3:0] exp;
        int         extra;
        acc = en && !m_vit && !m_der;
        exp = 4'b0000;
        if (acc) begin
            if (l > 4 || c > 6) exp = 4'b0001;
            else if (shot[l][c]) exp = 4'b0010;
            else begin
                shot[l][c] = 1'b1;
                m_rest--;
                if (ship[l][c]) begin m_hits++; exp = 4'b1000; end
                else exp = 4'b0100;
                if (exp[3] && m_ships > 0 && m_hits == m_ships) m_vit = 1'b1;
                else if (m_rest == 0) m_der = 1'b1;
            end
        end
        @(negedge clk); linha = 3'(l); coluna = 3'(c); enable = en; atirar = 1'b1;
        @(posedge clk); #1 chk("ocupado", ocupado, acc);
        @(posedge clk); #1 chk($sformatf("pulso(%0d,%0d)", l, c), {acerto, erro, repetido, invalido}, exp);
        extra = 0;
        repeat (hold) begin @(posedge clk); #1 extra += npulses(); end
        @(negedge clk); atirar = 1'b0; enable = 1'b1;
        repeat (2) begin @(posedge clk); #1 extra += npulses(); end
        chk("pulso_unico", extra, 0);
        chk_state();
    endtask

    initial begin
        set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
        model_clear();
        repeat (2) @(negedge clk);
        #1 chk_state();
        chk("pulsos_reset", {acerto, erro, repetido, invalido, ocupado}, 0);
        rst_n = 1'b1;

        // Hit, miss, repeat, invalid, held button
        fire(0, 4, 1, 0);
        fire(0, 0, 1, 0);
        fire(0, 4, 1, 0);
        fire(5, 0, 1, 0);
        fire(2, 7, 1, 0);
        fire(1, 0, 1, 20);
        fire(1, 1, 0, 0);   // gated by enable

        // Async reset in the middle of an evaluation aborts the shot
        @(negedge clk); linha = 3'd1; coluna = 3'd3; atirar = 1'b1;
        @(posedge clk); #1 chk("ocupado_pre_rst", ocupado, 1'b1);
        #2 rst_n = 1'b0;
        #1 model_clear(); chk_state();
        chk("pulsos_rst", {acerto, erro, repetido, invalido, ocupado}, 0);
        @(negedge clk); atirar = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 chk("sem_pulso_rst", npulses(), 0);

        // Victory: every ship cell, no misses
        novo_jogo();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++)
                if (ship[r][c]) fire(r, c, 1, 0);
        chk("vitoria_rest", rest, 2);
        fire(4, 4, 1, 0);   // ignored in FIM
        novo_jogo();

        // Defeat: 14 misses then a hit on the last shot
        begin
            int n = 0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 7; c++)
                    if (!ship[r][c] && n < 14) begin fire(r, c, 1, 0); n++; end
        end
        fire(0, 4, 1, 0);
        chk("derrota_final", {vitoria, derrota, rest}, {2'b01, 5'd0});

        // Empty map never wins
        set_map('0, '0, '0, '0, '0);
        novo_jogo();
        for (int i = 0; i < MAXT; i++) fire(i / 7, i % 7, 1, 0);
        chk("vazio_derrota", {vitoria, derrota}, 2'b01);

        // Random games
        for (int g = 0; g < 8; g++) begin
            set_map(7'($urandom & $urandom), 7'($urandom & $urandom), 7'($urandom & $urandom),
                    7'($urandom & $urandom), 7'($urandom & $urandom));
            novo_jogo();
            for (int s = 0; s < 30; s++) begin
                int l, c, p;
                p = int'($urandom_range(0, 99));
                l = int'($urandom_range(0, 4));
                c = int'($urandom_range(0, 6));
                if (p < 10) begin l = int'($urandom_range(0, 7)); c = int'($urandom_range(0, 7)); end
                else if (p < 60) begin
                    for (int r = 0; r < 5; r++)
                        for (int k = 0; k < 7; k++)
                            if (ship[r][k] && !shot[r][k]) begin l = r; c = k; end
                end
                fire(l, c, ($urandom_range(0, 9) != 0), int'($urandom_range(0, 2)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
